multicycle_control: RTL and testbench

//  Main multicycle control FSM of the RV32I core. Sequences fetch, decode, execute, memory and

---
 rtl/multicycle_control.sv | 217 +++++++++++++++++++++
 tb/tb_multicycle_control.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle control FSM for the RV32I core: fetch/decode/execute/mem/wb sequencing.
// Ports: CLK, RST_n, opcode, mem_ready in; datapath strobes, mux selects, alu_op, state_o,
// illegal out. Optional PERF_CNT_EN macro adds cycle_cnt and instret_cnt outputs.
module multicycle_control #(
  parameter int unsigned RESET_PC_HOLD = 1
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       branch,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [2:0] alu_op,
  output logic [3:0] state_o,
  output logic       illegal
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  typedef enum logic [3:0] {
    S_RESET   = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXEC_R  = 4'd7,
    S_EXEC_I  = 4'd8,
    S_EXEC_U  = 4'd9,
    S_ALUWB   = 4'd10,
    S_BRANCH  = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] HOLD_LAST = 4'(RESET_PC_HOLD - 1);

  state_t     state_q, state_d;
  logic [3:0] hold_q, hold_d;
  logic       illegal_q, illegal_d;
  logic       retire;

  logic is_mem, is_r, is_i, is_br, is_u;

  assign is_mem = (opcode == OP_LOAD) || (opcode == OP_STORE);
  assign is_r   = (opcode == OP_R);
  assign is_i   = (opcode == OP_I);
  assign is_br  = (opcode == OP_BRANCH);
  assign is_u   = (opcode == OP_LUI) || (opcode == OP_AUIPC);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q   <= S_RESET;
      hold_q    <= 4'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_d     = 4'd0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    alu_op     = 3'b000;
    retire     = 1'b0;
    case (state_q)
      S_RESET: begin
        if (hold_q == HOLD_LAST) state_d = S_FETCH;
        else hold_d = hold_q + 4'd1;
      end
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 3'b010;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALU computes oldPC + imm so the branch target is in ALUOut
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        alu_op    = 3'b010;
        unique case (1'b1)
          is_mem:  state_d = S_MEMADR;
          is_r:    state_d = S_EXEC_R;
          is_i:    state_d = S_EXEC_I;
          is_br:   state_d = S_BRANCH;
          is_u:    state_d = S_EXEC_U;
          default: state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 3'b010;
        // opcode[5] separates store from load
        state_d   = opcode[5] ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        adr_src  = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        result_src = 2'b01;
        state_d    = S_FETCH;
        retire     = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op    = 3'b000;
        state_d   = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 3'b011;
        state_d   = S_ALUWB;
      end
      S_EXEC_U: begin
        // LUI adds to zero, AUIPC adds to the instruction's PC
        alu_src_a = opcode[5] ? 2'b11 : 2'b01;
        alu_src_b = 2'b01;
        alu_op    = 3'b100;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        result_src = 2'b00;
        state_d    = S_FETCH;
        retire     = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 2'b10;
        alu_op     = 3'b001;
        branch     = 1'b1;
        result_src = 2'b00;
        state_d    = S_FETCH;
        retire     = 1'b1;
      end
      S_ILLEGAL: begin
        state_d = S_ILLEGAL;
      end
      default: begin
        state_d = S_RESET;
      end
    endcase
    illegal_d = illegal_q | (state_d == S_ILLEGAL);
  end

  assign state_o = state_q;
  assign illegal = illegal_q;

`ifdef PERF_CNT_EN
  logic [31:0] cycle_q, instret_q;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      cycle_q   <= 32'd0;
      instret_q <= 32'd0;
    end else begin
      if (state_q != S_RESET) cycle_q <= cycle_q + 32'd1;
      if (retire) instret_q <= instret_q + 32'd1;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: directed and randomized instruction streams
// checked against an instruction-level step-list reference model.
module tb_multicycle_control;

  localparam int HOLD = 1;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] RTYP  = 7'b0110011;
  localparam logic [6:0] ITYP  = 7'b0010011;
  localparam logic [6:0] BRAN  = 7'b1100011;
  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;
  localparam logic [6:0] BAD   = 7'b1111111;

  logic       CLK = 1'b0;
  logic       RST_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic       mem_ready = 1'b0;
  logic       pc_write, branch, ir_write, adr_src;
  logic       mem_read, mem_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] alu_op;
  logic [3:0] state_o;
  logic       illegal;
`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  multicycle_control #(.RESET_PC_HOLD(HOLD)) dut (
    .CLK(CLK),
    .RST_n(RST_n),
    .opcode(opcode),
    .mem_ready(mem_ready),
    .pc_write(pc_write),
    .branch(branch),
    .ir_write(ir_write),
    .adr_src(adr_src),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .reg_write(reg_write),
    .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b),
    .result_src(result_src),
    .alu_op(alu_op),
    .state_o(state_o),
    .illegal(illegal)
`ifdef PERF_CNT_EN
    ,
    .cycle_cnt(cycle_cnt),
    .instret_cnt(instret_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int code;
    bit waits;
  } step_t;

  step_t q[$];
  bit    ill_seen;
  int    exp_cycle;
  int    exp_instret;
  int    stalls;

  logic [15:0] got;
  assign got = {pc_write, branch, ir_write, adr_src, mem_read,
                mem_write, reg_write, alu_src_a, alu_src_b,
                result_src, alu_op};

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Datapath control expected for each step, straight from the state table
  function automatic logic [15:0] exp_vec(int code, logic [6:0] op,
                                          logic rdy);
    logic pw, br, ir, adr, mr, mw, rw;
    logic [1:0] a, b, rs;
    logic [2:0] ao;
    {pw, br, ir, adr, mr, mw, rw} = 7'b0;
    a = 2'b00; b = 2'b00; rs = 2'b00; ao = 3'b000;
    case (code)
      1: begin mr = 1; b = 2'b10; ao = 3'b010; ir = rdy; pw = rdy; end
      2: begin a = 2'b01; b = 2'b01; ao = 3'b010; end
      3: begin a = 2'b10; b = 2'b01; ao = 3'b010; end
      4: begin mr = 1; adr = 1; end
      5: begin rw = 1; rs = 2'b01; end
      6: begin mw = 1; adr = 1; end
      7: begin a = 2'b10; b = 2'b00; ao = 3'b000; end
      8: begin a = 2'b10; b = 2'b01; ao = 3'b011; end
      9: begin a = (op == LUI) ? 2'b11 : 2'b01; b = 2'b01; ao = 3'b100; end
      10: begin rw = 1; rs = 2'b00; end
      11: begin a = 2'b10; ao = 3'b001; br = 1; end
      default: ;
    endcase
    return {pw, br, ir, adr, mr, mw, rw, a, b, rs, ao};
  endfunction

  function automatic int base_cpi(logic [6:0] op);
    case (op)
      LOAD:    return 5;
      STORE:   return 4;
      BRAN:    return 3;
      default: return 4;
    endcase
  endfunction

  function automatic void push_instr(logic [6:0] op);
    q.push_back('{1, 1'b1});
    q.push_back('{2, 1'b0});
    case (op)
      LOAD: begin
        q.push_back('{3, 1'b0});
        q.push_back('{4, 1'b1});
        q.push_back('{5, 1'b0});
      end
      STORE: begin
        q.push_back('{3, 1'b0});
        q.push_back('{6, 1'b1});
      end
      RTYP: begin q.push_back('{7, 1'b0}); q.push_back('{10, 1'b0}); end
      ITYP: begin q.push_back('{8, 1'b0}); q.push_back('{10, 1'b0}); end
      LUI, AUIPC: begin
        q.push_back('{9, 1'b0});
        q.push_back('{10, 1'b0});
      end
      BRAN: q.push_back('{11, 1'b0});
      default: q.push_back('{12, 1'b0});
    endcase
  endfunction

  // One clock of stimulus and checking; advances the model afterwards
  task automatic cycle(input logic rdy, input string tag);
    step_t h;
    @(negedge CLK);
    mem_ready = rdy;
    #1;
    if (q.size() == 0) begin
      check({tag, " model_empty"}, 32'd1, 32'd0);
      return;
    end
    h = q[0];
    if (h.code == 12) ill_seen = 1;
    check({tag, " state"}, {28'd0, state_o}, h.code);
    check({tag, " ctrl"}, {16'd0, got}, {16'd0, exp_vec(h.code, opcode, rdy)});
    check({tag, " illegal"}, {31'd0, illegal}, {31'd0, ill_seen});
    check({tag, " rd_wr_excl"}, {31'd0, mem_read & mem_write}, 32'd0);
    check({tag, " pc_br_excl"}, {31'd0, pc_write & branch}, 32'd0);
`ifdef PERF_CNT_EN
    check({tag, " cycle_cnt"}, cycle_cnt, exp_cycle);
    check({tag, " instret_cnt"}, instret_cnt, exp_instret);
`endif
    if (h.code != 0) exp_cycle++;
    if (h.waits && !rdy) stalls++;
    if (h.code != 12 && (!h.waits || rdy)) begin
      void'(q.pop_front());
      if (h.code == 5 || h.code == 6 || h.code == 10 || h.code == 11)
        exp_instret++;
    end
  endtask

  task automatic do_reset(input string tag);
    RST_n = 1'b0;
    q.delete();
    ill_seen = 0;
    exp_cycle = 0;
    exp_instret = 0;
    @(negedge CLK);
    #1;
    check({tag, " rst_state"}, {28'd0, state_o}, 32'd0);
    check({tag, " rst_ctrl"}, {16'd0, got}, 32'd0);
    check({tag, " rst_illegal"}, {31'd0, illegal}, 32'd0);
    @(posedge CLK);
    #1;
    RST_n = 1'b1;
    for (int i = 0; i < HOLD; i++) q.push_back('{0, 1'b0});
    for (int i = 0; i < HOLD; i++) cycle(1'b1, {tag, " hold"});
  endtask

  // mode 0: memory always ready; 1: random stalls; 2: two stalls in S_MEMRD
  task automatic run_instr(input logic [6:0] op, input int mode,
                           input string tag);
    int cyc;
    int local_st;
    logic rdy;
    opcode = op;
    push_instr(op);
    stalls = 0;
    cyc = 0;
    local_st = 0;
    while (q.size() > 0 && cyc < 60) begin
      if (q[0].waits) begin
        case (mode)
          0: rdy = 1'b1;
          1: rdy = (local_st >= 3) || ($urandom % 3 != 0);
          default: rdy = !(q[0].code == 4 && local_st < 2);
        endcase
        if (!rdy) local_st++;
        else local_st = 0;
      end else begin
        rdy = 1'($urandom % 2);
      end
      cycle(rdy, tag);
      cyc++;
    end
    check({tag, " cpi"}, cyc, base_cpi(op) + stalls);
  endtask

  logic [6:0] ops [7];

  initial begin
    ops[0] = LOAD; ops[1] = STORE; ops[2] = RTYP; ops[3] = ITYP;
    ops[4] = BRAN; ops[5] = LUI; ops[6] = AUIPC;

    do_reset("t1");
    run_instr(RTYP, 0, "t2_rtype");
    run_instr(LOAD, 2, "t3_load");
    check("t3_stalls", stalls, 2);
    run_instr(BRAN, 0, "t4_branch");
    run_instr(LUI, 0, "lui");
    run_instr(AUIPC, 0, "auipc");
    run_instr(ITYP, 0, "itype");
    run_instr(STORE, 0, "store");

    for (int n = 0; n < 40; n++)
      run_instr(ops[$urandom % 7], 1, $sformatf("rnd%0d", n));

    opcode = BAD;
    push_instr(BAD);
    for (int i = 0; i < 6; i++) cycle(1'($urandom % 2), "t5_illegal");
    do_reset("t5_after");

    run_instr(RTYP, 0, "t6_r");
    run_instr(STORE, 1, "t6_st");
`ifdef PERF_CNT_EN
    @(negedge CLK);
    #1;
    check("t6_instret2", instret_cnt, 32'd2);
    q.delete();
    q.push_back('{1, 1'b1});
    exp_instret = 2;
    exp_cycle++;
    opcode = RTYP;
    q.delete();
    push_instr(STORE);
    void'(q.pop_front());
    cycle(1'b1, "t6_fetch_done");
`else
    push_instr(STORE);
    opcode = STORE;
    cycle(1'b1, "t6_fetch");
`endif
    cycle(1'b0, "t6_decode");
    cycle(1'b0, "t6_memadr");
    @(negedge CLK);
    mem_ready = 1'b0;
    #1;
    check("t6_memwr_state", {28'd0, state_o}, 32'd6);
    check("t6_memwr_on", {31'd0, mem_write}, 32'd1);
    RST_n = 1'b0;
    #1;
    check("t6_abort_wr", {31'd0, mem_write}, 32'd0);
    check("t6_abort_state", {28'd0, state_o}, 32'd0);
    do_reset("t6_end");
    run_instr(BRAN, 1, "post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
